delay_ram_server: RTL and testbench

DELAY_RAM_SERVER -- requirements
Module: delay_ram_server

---
 rtl/delay_ram_pkg.sv | 15 +
 rtl/delay_ram_mem.sv | 26 ++
 rtl/delay_ram_server.sv | 152 +++++++++++++++
 tb/tb_delay_ram_server.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_ram_pkg.sv
// Shared types and constants for the delay-line RAM server.
// DELAY_RAM_SERVER_CLEAR_EN adds the CLEAR state used to zero the RAM after reset.
package delay_ram_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 13;
  localparam int SAMPLERATE     = 48000;

`ifdef DELAY_RAM_SERVER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, CLEAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_e;
`endif

endpackage

// File: rtl/delay_ram_mem.sv
// Single-port synchronous RAM with registered read; a write cycle leaves rdata unchanged.
module delay_ram_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/delay_ram_server.sv
// Circular delay-line server: writes take priority over reads on the single RAM port.
// Define DELAY_RAM_SERVER_CLEAR_EN to zero the whole RAM after every reset.
module delay_ram_server
  import delay_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  sram_rd,
  input  logic [ADDR_WIDTH-1:0] sram_offset,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_read_finish,
  output logic                  busy,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  finish_q, finish_d;
  logic                  err_q, err_d;
  logic                  rd_wait_q, rd_wait_d;
`ifdef DELAY_RAM_SERVER_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

  logic                  wr_ok;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr, rd_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  // Newest sample lives at wr_ptr-1; the pointer is taken in the cycle the read issues.
  assign rd_addr = wr_ptr_q - ADDR_WIDTH'(1) - offset_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    offset_d  = offset_q;
    data_d    = data_q;
    finish_d  = 1'b0;
    err_d     = err_q;
    rd_wait_d = rd_wait_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = wr_data;
    wr_ok     = wr;
`ifdef DELAY_RAM_SERVER_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) wr_ok = 1'b0;
`endif
    if (wr_ok) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (sram_rd && state_q != IDLE) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (sram_rd) begin
          offset_d = sram_offset;
          state_d  = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        // A colliding write owns the port; the read retries next cycle.
        if (!wr_ok) begin
          ram_en    = 1'b1;
          ram_addr  = rd_addr;
          rd_wait_d = 1'b0;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_wait_q) begin
          data_d    = ram_rdata;
          finish_d  = 1'b1;
          rd_wait_d = 1'b0;
          state_d   = IDLE;
        end else begin
          rd_wait_d = 1'b1;
        end
      end
`ifdef DELAY_RAM_SERVER_CLEAR_EN
      CLEAR: begin
        if (wr) err_d = 1'b1;
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (&clr_cnt_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef DELAY_RAM_SERVER_CLEAR_EN
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
`else
      state_q   <= IDLE;
`endif
      wr_ptr_q  <= '0;
      data_q    <= '0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
      rd_wait_q <= 1'b0;
    end else begin
`ifdef DELAY_RAM_SERVER_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      data_q    <= data_d;
      finish_q  <= finish_d;
      err_q     <= err_d;
      rd_wait_q <= rd_wait_d;
    end
  end

  always_ff @(posedge clk) begin
    offset_q <= offset_d;
  end

  delay_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign sram_data_in     = data_q;
  assign sram_read_finish = finish_q;
  assign busy             = (state_q != IDLE);
  assign err              = err_q;

endmodule

// File: tb/tb_delay_ram_server.sv
// Directed bench for delay_ram_server; clear-feature scenario builds with DELAY_RAM_SERVER_CLEAR_EN.
module tb_delay_ram_server;

  localparam int DW = 16;
  localparam int AW = 13;
`ifdef DELAY_RAM_SERVER_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          sram_rd = 1'b0;
  logic [AW-1:0] sram_offset = '0;
  logic [DW-1:0] sram_data_in;
  logic          sram_read_finish;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_ram_server #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (wr),
    .wr_data         (wr_data),
    .sram_rd         (sram_rd),
    .sram_offset     (sram_offset),
    .sram_data_in    (sram_data_in),
    .sram_read_finish(sram_read_finish),
    .busy            (busy),
    .err             (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 9000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle();
  endtask

  task automatic write_seq(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      wr      = 1'b1;
      wr_data = DW'(first + k);
      tick();
    end
    wr = 1'b0;
  endtask

  // Returns latency in edges after the sampling edge (-1 if no pulse within 20 edges).
  task automatic do_read(input int off, output logic [DW-1:0] d, output int lat,
                         output int pulses, output logic busy_n);
    sram_rd     = 1'b1;
    sram_offset = AW'(off);
    tick();
    sram_rd = 1'b0;
    busy_n  = busy;
    lat     = -1;
    pulses  = 0;
    d       = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sram_read_finish) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          d   = sram_data_in;
        end
      end
    end
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (sram_read_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b exp 0", sram_read_finish); end
    checks++; if (sram_data_in !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", sram_data_in); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (busy !== CLR) begin errors++; $display("FAIL reset_busy got %b exp %b", busy, CLR); end
    rst = 1'b0;
    wait_idle();
  endtask

  task automatic test_basic;
    logic [DW-1:0] d;
    int lat, pulses;
    logic bz;
    write_seq(1, 20);
    do_read(0, d, lat, pulses, bz);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic0_latency got %0d exp 3", lat); end
    checks++; if (d !== 16'd20) begin errors++; $display("FAIL basic0_data got %0d exp 20", d); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic0_pulses got %0d exp 1", pulses); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL basic0_busy got %b exp 1", bz); end
    do_read(5, d, lat, pulses, bz);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic5_latency got %0d exp 3", lat); end
    checks++; if (d !== 16'd15) begin errors++; $display("FAIL basic5_data got %0d exp 15", d); end
    checks++; if (sram_data_in !== 16'd15) begin errors++; $display("FAIL basic_hold got %0d exp 15", sram_data_in); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err); end
  endtask

  task automatic test_same_cycle;
    logic [DW-1:0] d;
    int lat, pulses;
    logic bz;
    wr      = 1'b1;
    wr_data = 16'd77;
    sram_rd = 1'b1;
    sram_offset = '0;
    tick();
    wr = 1'b0;
    sram_rd = 1'b0;
    lat = -1;
    d = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sram_read_finish && lat < 0) begin
        lat = i;
        d   = sram_data_in;
      end
    end
    bz = busy;
    checks++; if (lat !== 3) begin errors++; $display("FAIL same_latency got %0d exp 3", lat); end
    checks++; if (d !== 16'd77) begin errors++; $display("FAIL same_data got %0d exp 77", d); end
    checks++; if (bz !== 1'b0) begin errors++; $display("FAIL same_idle_busy got %b exp 0", bz); end
  endtask

  task automatic test_collision;
    logic [DW-1:0] d;
    int lat, pulses;
    sram_rd = 1'b1;
    sram_offset = '0;
    tick();
    sram_rd = 1'b0;
    wr      = 1'b1;
    wr_data = 16'd99;
    tick();
    wr = 1'b0;
    lat = sram_read_finish ? 1 : -1;
    pulses = sram_read_finish ? 1 : 0;
    d = '0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (sram_read_finish) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          d   = sram_data_in;
        end
      end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL collide_latency got %0d exp 4", lat); end
    checks++; if (d !== 16'd99) begin errors++; $display("FAIL collide_data got %0d exp 99", d); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL collide_pulses got %0d exp 1", pulses); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL collide_err got %b exp 0", err); end
  endtask

  task automatic test_busy_read;
    logic [DW-1:0] d;
    int pulses;
    sram_rd = 1'b1;
    sram_offset = '0;
    tick();
    sram_offset = AW'(7);
    tick();
    sram_rd = 1'b0;
    pulses = sram_read_finish ? 1 : 0;
    d = sram_data_in;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sram_read_finish) begin
        pulses++;
        d = sram_data_in;
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busyrd_pulses got %0d exp 1", pulses); end
    checks++; if (d !== 16'd99) begin errors++; $display("FAIL busyrd_data got %0d exp 99", d); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL busyrd_err got %b exp 1", err); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] d;
    int lat, pulses;
    logic bz;
    do_reset();
    write_seq(0, 8195);
    do_read(10, d, lat, pulses, bz);
    checks++; if (d !== 16'd8184) begin errors++; $display("FAIL wrap10_data got %0d exp 8184", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wrap10_latency got %0d exp 3", lat); end
    do_read(0, d, lat, pulses, bz);
    checks++; if (d !== 16'd8194) begin errors++; $display("FAIL wrap0_data got %0d exp 8194", d); end
    do_read(3, d, lat, pulses, bz);
    checks++; if (d !== 16'd8191) begin errors++; $display("FAIL wrap3_data got %0d exp 8191", d); end
  endtask

`ifdef DELAY_RAM_SERVER_CLEAR_EN
  task automatic test_clear;
    logic [DW-1:0] d;
    int lat, pulses, cnt;
    logic bz;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 10000) begin
      if (cnt == 100) begin
        wr = 1'b1;
        wr_data = 16'd1234;
      end else begin
        wr = 1'b0;
      end
      tick();
      cnt++;
    end
    wr = 1'b0;
    checks++; if (cnt !== 8192) begin errors++; $display("FAIL clear_busy_cycles got %0d exp 8192", cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL clear_wr_err got %b exp 1", err); end
    checks++; if (dut.wr_ptr_q !== '0) begin errors++; $display("FAIL clear_wr_ptr got %0d exp 0", dut.wr_ptr_q); end
    do_read(100, d, lat, pulses, bz);
    checks++; if (d !== '0) begin errors++; $display("FAIL clear_read_data got %0d exp 0", d); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL clear_read_latency got %0d exp 3", lat); end
  endtask
`endif

  task automatic test_reset_mid_read;
    int pulses;
    write_seq(5, 4);
    sram_rd = 1'b1;
    sram_offset = '0;
    tick();
    tick();
    sram_rd = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL midrst_pre_err got %b exp 1", err); end
    rst = 1'b1;
    #1;
    checks++; if (dut.wr_ptr_q !== '0) begin errors++; $display("FAIL midrst_wr_ptr got %0d exp 0", dut.wr_ptr_q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", err); end
    checks++; if (busy !== CLR) begin errors++; $display("FAIL midrst_busy got %b exp %b", busy, CLR); end
    pulses = sram_read_finish ? 1 : 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sram_read_finish) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_pulses got %0d exp 0", pulses); end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_collision();
    test_busy_read();
    test_wrap();
`ifdef DELAY_RAM_SERVER_CLEAR_EN
    test_clear();
`endif
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
